elink_axi_wr_master: RTL and testbench



---
 rtl/elink_axi_pkg.sv | 22 ++
 rtl/elink_id_fifo.sv | 68 ++++++
 rtl/elink_axi_wr_master.sv | 175 +++++++++++++++++
 tb/tb_elink_axi_wr_master.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elink_axi_pkg.sv
// Shared AXI3 constants and types for the elink write master.
package elink_axi_pkg;

  localparam int ID_W_DEF = 12;

  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef logic [ID_W_DEF-1:0] axi_id_t;

  // Saturating 16-bit increment used by the error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/elink_id_fifo.sv
// Small synchronous FIFO holding the IDs of writes awaiting a B response.
// Push and pop may happen in the same cycle, including when full.
module elink_id_fifo
  import elink_axi_pkg::*;
#(
  parameter int WIDTH = ID_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Advance a pointer, wrapping at the configured depth (which need not fill the pointer range).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/elink_axi_wr_master.sv
// Single-beat AXI3 write master feeding the elink slave write port.
// One host request becomes one AW beat plus one W beat; B responses are
// matched in order against the IDs that were issued.
module elink_axi_wr_master
  import elink_axi_pkg::*;
#(
  parameter int ID_W    = 12,
  parameter int MAX_OUT = 4,
  parameter int ID_BASE = 0
) (
  input  logic            m_axi_aclk,
  input  logic            m_axi_aresetn,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_data,
  input  logic [3:0]      req_strb,

  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [31:0]     m_axi_awaddr,
  output logic [ID_W-1:0] m_axi_awid,
  output logic [7:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  output logic [1:0]      m_axi_awlock,
  output logic [3:0]      m_axi_awcache,
  output logic [2:0]      m_axi_awprot,
  output logic [3:0]      m_axi_awqos,

  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  output logic [ID_W-1:0] m_axi_wid,
  output logic            m_axi_wlast,

  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  input  logic [ID_W-1:0] m_axi_bid,
  input  logic [1:0]      m_axi_bresp,

  output logic            resp_valid,
  output logic            resp_err,
  output logic [15:0]     err_count,
  output logic [4:0]      outstanding
);

  logic [ID_W-1:0] next_id;
  logic [ID_W-1:0] fifo_head;
  logic            fifo_empty;
  logic            fifo_full;
  logic            accept;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            b_err;

  // Every beat is a single 4-byte INCR transfer with bufferable/modifiable cache attributes.
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = AXI_CACHE_BUFMOD;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wlast   = 1'b1;

  // Ready depends on registered state only so the requester never sees a
  // combinational loop through req_valid. The FIFO flags always track
  // outstanding; folding them in keeps the two views from ever diverging.
  assign req_ready    = !m_axi_awvalid && !m_axi_wvalid &&
                        (outstanding < 5'(MAX_OUT)) && !fifo_full;
  assign m_axi_bready = (outstanding != 5'd0) && !fifo_empty;

  assign accept = req_valid && req_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign b_err  = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != fifo_head);

  elink_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .push      (accept),
    .push_data (next_id),
    .pop       (b_hs),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Capture the request payload and ID; held stable while either valid is up.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      m_axi_awid   <= '0;
      m_axi_wid    <= '0;
    end else if (accept) begin
      m_axi_awaddr <= req_addr;
      m_axi_wdata  <= req_data;
      m_axi_wstrb  <= req_strb;
      m_axi_awid   <= next_id;
      m_axi_wid    <= next_id;
    end
  end

  // AW and W valids rise together on accept and fall independently on their own handshakes.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
    end else begin
      if (accept) begin
        m_axi_awvalid <= 1'b1;
      end else if (aw_hs) begin
        m_axi_awvalid <= 1'b0;
      end
      if (accept) begin
        m_axi_wvalid <= 1'b1;
      end else if (w_hs) begin
        m_axi_wvalid <= 1'b0;
      end
    end
  end

  // Next ID to issue; wraps naturally at the ID width.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      next_id <= ID_W'(ID_BASE);
    end else if (accept) begin
      next_id <= next_id + ID_W'(1);
    end
  end

  // Writes issued but not yet responded; an accept and a B handshake together cancel out.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      outstanding <= 5'd0;
    end else begin
      case ({accept, b_hs})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // One-cycle response pulse per B handshake, flagging bad status or an out-of-order ID.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= b_hs;
      resp_err   <= b_hs && b_err;
    end
  end

  // Saturating tally of errored responses, bumped on each resp_err pulse.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      err_count <= 16'd0;
    end else if (resp_err) begin
      err_count <= sat_inc16(err_count);
    end
  end

endmodule

// File: tb/tb_elink_axi_wr_master.sv
// Directed self-checking bench for elink_axi_wr_master; the bench plays the AXI slave.
module tb_elink_axi_wr_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [11:0] awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [11:0] wid;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] err_count;
  logic [4:0]  outstanding;

  int vec_count  = 0;
  int miss_count = 0;
  int resp_pulses = 0;

  elink_axi_wr_master #(
    .ID_W    (12),
    .MAX_OUT (4),
    .ID_BASE (0)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_strb      (req_strb),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awid    (awid),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awlock  (awlock),
    .m_axi_awcache (awcache),
    .m_axi_awprot  (awprot),
    .m_axi_awqos   (awqos),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wid     (wid),
    .m_axi_wlast   (wlast),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_bid     (bid),
    .m_axi_bresp   (bresp),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .err_count     (err_count),
    .outstanding   (outstanding)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count response pulses on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (resp_valid) resp_pulses++;
  end

  // Hard stop in case something unforeseen stalls the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, wait (bounded) for acceptance, then check the issued beat.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [11:0] exp_id);
    int n;
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      checkOutput("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      tick();
      req_valid = 1'b0;
      checkOutput("awvalid_set", awvalid, 1);
      checkOutput("wvalid_set", wvalid, 1);
      checkOutput("awid", awid, exp_id);
      checkOutput("wid", wid, exp_id);
      checkOutput("awaddr", awaddr, a);
      checkOutput("wdata", wdata, d);
      checkOutput("wstrb", wstrb, s);
    end
  endtask

  // Present one B beat, wait (bounded) for bready, then check the response pulse.
  task automatic sendResponse(input logic [11:0] id, input logic [1:0] resp, input logic exp_err);
    int n;
    bid    = id;
    bresp  = resp;
    bvalid = 1'b1;
    n = 0;
    while (!bready && n < 50) begin
      tick();
      n++;
    end
    if (!bready) begin
      bvalid = 1'b0;
      checkOutput("bready_timeout", 32'd0, 32'd1);
    end else begin
      tick();
      bvalid = 1'b0;
      checkOutput("resp_valid", resp_valid, 1);
      checkOutput("resp_err", resp_err, exp_err);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = 2'b00;

    // Reset state.
    #2;
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_awid", awid, 0);
    checkOutput("rst_awaddr", awaddr, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_req_ready", req_ready, 1);

    // Single write with a responsive slave.
    applyStimulus(32'h8090_0000, 32'hDEAD_BEEF, 4'hF, 12'd0);
    checkOutput("single_wlast", wlast, 1);
    checkOutput("single_awlen", awlen, 0);
    checkOutput("single_awsize", awsize, 3'b010);
    checkOutput("single_awburst", awburst, 2'b01);
    checkOutput("single_awcache", awcache, 4'b0011);
    checkOutput("single_awlock", awlock, 0);
    checkOutput("single_awprot", awprot, 0);
    checkOutput("single_awqos", awqos, 0);
    checkOutput("single_outstanding", outstanding, 1);
    tick();
    checkOutput("single_aw_done", awvalid, 0);
    checkOutput("single_w_done", wvalid, 0);
    sendResponse(12'd0, 2'b00, 1'b0);
    checkOutput("single_outstanding_end", outstanding, 0);
    checkOutput("single_bready_end", bready, 0);

    // Skew case 1: AW completes first, W stalled for 5 cycles.
    awready = 1'b1;
    wready  = 1'b0;
    applyStimulus(32'h0000_1000, 32'h1234_5678, 4'h3, 12'd1);
    tick();
    checkOutput("skew1_aw_done", awvalid, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("skew1_wvalid_hold", wvalid, 1);
      checkOutput("skew1_wdata_hold", wdata, 32'h1234_5678);
      checkOutput("skew1_req_ready_low", req_ready, 0);
      tick();
    end
    wready = 1'b1;
    tick();
    checkOutput("skew1_w_done", wvalid, 0);
    checkOutput("skew1_req_ready_back", req_ready, 1);
    sendResponse(12'd1, 2'b00, 1'b0);

    // Skew case 2: W completes first, AW stalled for 5 cycles.
    awready = 1'b0;
    wready  = 1'b1;
    applyStimulus(32'h0000_2004, 32'hCAFE_F00D, 4'hC, 12'd2);
    tick();
    checkOutput("skew2_w_done", wvalid, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("skew2_awvalid_hold", awvalid, 1);
      checkOutput("skew2_awaddr_hold", awaddr, 32'h0000_2004);
      checkOutput("skew2_req_ready_low", req_ready, 0);
      tick();
    end
    awready = 1'b1;
    tick();
    checkOutput("skew2_aw_done", awvalid, 0);
    checkOutput("skew2_req_ready_back", req_ready, 1);
    sendResponse(12'd2, 2'b00, 1'b0);
    checkOutput("skew_outstanding_end", outstanding, 0);

    // Outstanding limit: four accepted, the rest held off until responses drain.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h4000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 12'(i));
    end
    tick();
    checkOutput("full_outstanding", outstanding, 4);
    req_addr  = 32'h4000_0010;
    req_data  = 32'hA000_0004;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("full_req_ready_low", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    checkOutput("full_no_extra_accept", outstanding, 4);
    checkOutput("full_awvalid_idle", awvalid, 0);
    p0 = resp_pulses;
    for (int i = 0; i < 4; i++) begin
      sendResponse(12'(i), 2'b00, 1'b0);
    end
    tick();
    checkOutput("full_resp_pulses", resp_pulses - p0, 4);
    checkOutput("full_drained", outstanding, 0);
    checkOutput("full_err_count", err_count, 0);
    applyStimulus(32'h4000_0010, 32'hA000_0004, 4'hF, 12'd4);
    tick();
    sendResponse(12'd4, 2'b00, 1'b0);

    // Error responses: SLVERR on the 2nd write, wrong ID on the 3rd.
    doReset();
    applyStimulus(32'h5000_0000, 32'h1111_1111, 4'hF, 12'd0);
    tick();
    sendResponse(12'd0, 2'b00, 1'b0);
    applyStimulus(32'h5000_0004, 32'h2222_2222, 4'hF, 12'd1);
    tick();
    sendResponse(12'd1, 2'b10, 1'b1);
    tick();
    checkOutput("err_count_slverr", err_count, 1);
    applyStimulus(32'h5000_0008, 32'h3333_3333, 4'hF, 12'd2);
    tick();
    sendResponse(12'd5, 2'b00, 1'b1);
    tick();
    checkOutput("err_count_badid", err_count, 2);
    checkOutput("err_outstanding", outstanding, 0);

    // Accept and B handshake in the same cycle.
    applyStimulus(32'h6000_0000, 32'h4444_4444, 4'hF, 12'd3);
    applyStimulus(32'h6000_0004, 32'h5555_5555, 4'hF, 12'd4);
    tick();
    checkOutput("sim_pre_outstanding", outstanding, 2);
    checkOutput("sim_pre_req_ready", req_ready, 1);
    req_addr  = 32'h6000_0008;
    req_data  = 32'h6666_6666;
    req_strb  = 4'h1;
    req_valid = 1'b1;
    bid       = 12'd3;
    bresp     = 2'b00;
    bvalid    = 1'b1;
    tick();
    req_valid = 1'b0;
    bvalid    = 1'b0;
    checkOutput("sim_outstanding", outstanding, 2);
    checkOutput("sim_awid", awid, 12'd5);
    checkOutput("sim_resp_valid", resp_valid, 1);
    checkOutput("sim_resp_err", resp_err, 0);
    tick();
    sendResponse(12'd4, 2'b00, 1'b0);
    sendResponse(12'd5, 2'b00, 1'b0);
    tick();
    checkOutput("sim_outstanding_end", outstanding, 0);
    checkOutput("sim_err_count", err_count, 2);

    // Reset asserted between edges while a write is in flight.
    awready = 1'b0;
    wready  = 1'b0;
    applyStimulus(32'h7000_0000, 32'h7777_7777, 4'hF, 12'd6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_awvalid", awvalid, 0);
    checkOutput("midrst_wvalid", wvalid, 0);
    checkOutput("midrst_outstanding", outstanding, 0);
    checkOutput("midrst_err_count", err_count, 0);
    checkOutput("midrst_bready", bready, 0);
    tick();
    tick();
    rst_n   = 1'b1;
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    applyStimulus(32'h7000_0100, 32'h8888_8888, 4'hF, 12'd0);
    tick();
    sendResponse(12'd0, 2'b00, 1'b0);
    checkOutput("post_rst_outstanding", outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
